dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 64: data RAM depth in 32-bit words (power of two, 16..1024).
REQ-002 Parameter TX_DEPTH, default 4: TX FIFO depth in bytes (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low (0 = reset), sampled on the clk rising edge.
REQ-005 MemWrite  input  1  store strobe from the core; one write per cycle when 1.
REQ-006 ALUResult  input  32  byte address from the core; bits [1:0] ignored (word access only).
REQ-007 WriteData  input  32  store data from the core.
REQ-008 ReadData  output  32  load data to the core; combinational from ALUResult within the same cycle.
REQ-009 timer_irq  output  1  registered timer interrupt, level.
REQ-010 tx_valid  output  1  TX FIFO non-empty.
REQ-011 tx_data  output  8  TX FIFO head byte; stable while tx_valid=1 and tx_ready=0.
REQ-012 tx_ready  input  1  consumer accepts the head byte when tx_valid=1 and tx_ready=1.

Function
REQ-013 Address map: RAM at 0x0000_0000 .. RAM_WORDS*4-1; MMIO at 0x8000_0000 .. 0x8000_0017; all else unmapped.
REQ-014 RAM: write takes effect at the clk edge when MemWrite=1; asynchronous read; read of the address written in the same cycle returns the old word.
REQ-015 MMIO offset 0x00 TXDATA: write pushes WriteData[7:0]; read returns {full, 31'b0}.
REQ-016 MMIO offset 0x04 TXSTAT: read returns {23'b0, overflow, 3'b0, count[4:0]}; any write clears overflow.
REQ-017 MMIO offsets 0x08/0x0C MTIME_LO/HI and 0x10/0x14 MTIMECMP_LO/HI: read/write the 32-bit halves.
REQ-018 Unmapped read returns 0; unmapped write is ignored; no error signalled.
REQ-019 mtime: 64-bit counter, +1 every cycle, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 In a cycle with a write to MTIME_LO or MTIME_HI, the written half takes WriteData, the other half holds, and no increment occurs.
REQ-021 timer_irq is set on the edge following any cycle in which mtime >= mtimecmp (unsigned 64-bit compare, pre-update values); otherwise 0.
REQ-022 Push when not full: byte enters the tail; count+1.
REQ-023 Push when full and no pop in the same cycle: byte dropped, overflow set (sticky), count unchanged.
REQ-024 Pop: when tx_valid=1 and tx_ready=1, the head advances and count-1.
REQ-025 Simultaneous push and pop: both succeed and count is unchanged, including when full. When empty, no pop occurs (tx_valid=0), so the push alone succeeds.
REQ-026 Pointers wrap modulo TX_DEPTH; count ranges 0..TX_DEPTH; full = (count == TX_DEPTH).
REQ-027 A TXSTAT write and an overflow event in the same cycle leave overflow=1.

Reset
REQ-028 While reset=0 at an edge: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, timer_irq=0, FIFO count=0 with pointers at 0, tx_valid=0, overflow=0.
REQ-029 Reset mid-operation discards queued TX bytes immediately; tx_valid=0 from the first post-edge cycle.
REQ-030 RAM contents are not reset; MemWrite is ignored while reset=0.

Structure
REQ-031 The address-map base constants, MMIO offset enum and register bit positions live in riscv_pkg.
REQ-032 The FIFO is a sub-module tx_fifo (push/pop/full/count/overflow); dmem_mmio instantiates it alongside the RAM array, mtime/mtimecmp and the read mux.

Verification
REQ-033 Store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 -> ReadData=0xDEAD_BEEF; load 0x0000_0013 -> same word.
REQ-034 Hold tx_ready=0 and push 5 bytes 0x41..0x45 -> count=4, TXSTAT=0x0000_0104, tx_data=0x41; raise tx_ready -> bytes 0x41..0x44 delivered in order.
REQ-035 FIFO full with tx_ready=1, push 0x55 -> no overflow, count stays 4, 0x55 delivered last.
REQ-036 Write MTIMECMP_HI=0, MTIMECMP_LO=0x20 after reset -> timer_irq rises on the edge after mtime reaches 0x20; write MTIMECMP_HI=0xFFFF_FFFF -> timer_irq drops on the next edge.
REQ-037 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF on consecutive cycles -> mtime wraps to 0 two cycles later; read MTIME_HI=0.
REQ-038 Assert reset=0 with 3 bytes queued and timer_irq=1 -> next cycle tx_valid=0, timer_irq=0, TXSTAT=0, MTIME_LO reads 0 then increments once reset=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared address map, MMIO register offsets and register bit positions
// for the data-memory / MMIO slice.
`timescale 1ns/1ps
package riscv_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // Word offset within the MMIO window (byte offset >> 2)
  typedef enum logic [2:0] {
    MMIO_TXDATA      = 3'd0,
    MMIO_TXSTAT      = 3'd1,
    MMIO_MTIME_LO    = 3'd2,
    MMIO_MTIME_HI    = 3'd3,
    MMIO_MTIMECMP_LO = 3'd4,
    MMIO_MTIMECMP_HI = 3'd5
  } mmio_off_e;

  localparam int unsigned TXDATA_FULL_BIT = 31;
  localparam int unsigned TXSTAT_OVF_BIT  = 8;
  localparam int unsigned TXSTAT_CNT_W    = 5;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte-wide TX FIFO with sticky overflow flag; a push into a full FIFO
// succeeds only when a pop happens in the same cycle.
`timescale 1ns/1ps
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       ready_i,
  input  logic                       clr_ovf_i,
  output logic                       valid_o,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    buf_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (count_q != '0) && ready_i;
  assign push_ok = push_i && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    // A dropped byte wins over a clear issued in the same cycle
    if (push_i && full && !pop) ovf_d = 1'b1;
    else if (clr_ovf_i)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) buf_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = buf_q[rd_ptr_q];
  assign full_o  = full;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/dmem_mmio.sv
// Core data-memory port: word RAM with asynchronous read, plus an MMIO
// window holding a TX byte FIFO and a 64-bit mtime/mtimecmp timer.
`timescale 1ns/1ps
module dmem_mmio
  import riscv_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int unsigned CW        = $clog2(TX_DEPTH) + 1;

  logic [31:0]   mem_q [RAM_WORDS];
  logic [31:0]   ram_off;
  logic          ram_sel, mmio_sel, we, mmio_we;
  mmio_off_e     off;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          irq_q;
  logic          fifo_full, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   rdata;

  assign ram_off  = ALUResult - RAM_BASE;
  assign ram_sel  = (ram_off < RAM_BYTES);
  assign mmio_sel = (ALUResult[31:5] == MMIO_BASE[31:5]) && (ALUResult[4:2] <= MMIO_MTIMECMP_HI);
  assign off      = mmio_off_e'(ALUResult[4:2]);
  assign we       = MemWrite && reset;
  assign mmio_we  = we && mmio_sel;

  always_ff @(posedge clk) begin
    if (we && ram_sel) mem_q[ram_off[AW+1:2]] <= WriteData;
  end

  // A write to either mtime half replaces that cycle's increment
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (mmio_we) begin
      case (off)
        MMIO_MTIME_LO:    mtime_d    = {mtime_q[63:32], WriteData};
        MMIO_MTIME_HI:    mtime_d    = {WriteData, mtime_q[31:0]};
        MMIO_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], WriteData};
        MMIO_MTIMECMP_HI: mtimecmp_d = {WriteData, mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  tx_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_i   (mmio_we && (off == MMIO_TXDATA)),
    .data_i   (WriteData[7:0]),
    .ready_i  (tx_ready),
    .clr_ovf_i(mmio_we && (off == MMIO_TXSTAT)),
    .valid_o  (tx_valid),
    .data_o   (tx_data),
    .full_o   (fifo_full),
    .count_o  (fifo_count),
    .ovf_o    (fifo_ovf)
  );

  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = mem_q[ram_off[AW+1:2]];
    end else if (mmio_sel) begin
      case (off)
        MMIO_TXDATA: rdata[TXDATA_FULL_BIT] = fifo_full;
        MMIO_TXSTAT: begin
          rdata[TXSTAT_OVF_BIT]         = fifo_ovf;
          rdata[TXSTAT_CNT_W-1:0]       = TXSTAT_CNT_W'(fifo_count);
        end
        MMIO_MTIME_LO:    rdata = mtime_q[31:0];
        MMIO_MTIME_HI:    rdata = mtime_q[63:32];
        MMIO_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        MMIO_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        default: rdata = '0;
      endcase
    end
  end

  assign ReadData  = rdata;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, TX FIFO, timer and reset behaviour.
`timescale 1ns/1ps
module tb_dmem_mmio;

  localparam logic [31:0] A_TXDATA = 32'h8000_0000;
  localparam logic [31:0] A_TXSTAT = 32'h8000_0004;
  localparam logic [31:0] A_MTLO   = 32'h8000_0008;
  localparam logic [31:0] A_MTHI   = 32'h8000_000C;
  localparam logic [31:0] A_CMPLO  = 32'h8000_0010;
  localparam logic [31:0] A_CMPHI  = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        timer_irq;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dmem_mmio #(
    .RAM_WORDS(64),
    .TX_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .timer_irq(timer_irq),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    ALUResult = addr;
    WriteData = data;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemWrite  = 1'b0;
    ALUResult = addr;
    #1;
    check(tag, ReadData, exp);
  endtask

  initial begin
    int n;
    reset = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; tx_ready = 1'b0;
    repeat (3) cyc();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    rd_chk("rst_mtime_lo", A_MTLO, 32'h0);
    rd_chk("rst_txstat", A_TXSTAT, 32'h0);
    rd_chk("rst_cmp_hi", A_CMPHI, 32'hFFFF_FFFF);
    reset = 1'b1;
    cyc();

    // RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    MemWrite = 1'b1; ALUResult = 32'h0000_0010; WriteData = 32'h1234_5678;
    #1;
    check("ram_old_word", ReadData, 32'hDEAD_BEEF);
    cyc();
    rd_chk("ram_new_word", 32'h0000_0010, 32'h1234_5678);
    wr(32'h0000_0000, 32'h0BAD_F00D);
    wr(32'h0000_00FC, 32'hA5A5_5A5A);
    wr(32'h0000_0100, 32'h1111_1111);
    wr(32'h8000_0018, 32'h2222_2222);
    rd_chk("ram_last", 32'h0000_00FC, 32'hA5A5_5A5A);
    rd_chk("unmapped_ram", 32'h0000_0100, 32'h0);
    rd_chk("no_alias_w0", 32'h0000_0000, 32'h0BAD_F00D);
    rd_chk("unmapped_mmio", 32'h8000_0018, 32'h0);

    // FIFO fill and overflow
    for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'(8'h41 + i));
    rd_chk("txstat_ovf", A_TXSTAT, 32'h0000_0104);
    rd_chk("txdata_full", A_TXDATA, 32'h8000_0000);
    check("head_41", 32'(tx_data), 32'h41);
    check("valid_full", 32'(tx_valid), 32'd1);
    wr(A_TXSTAT, 32'h0);
    rd_chk("txstat_clr", A_TXSTAT, 32'h0000_0004);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(tx_valid), 32'd1);
      check("drain_byte", 32'(tx_data), 32'(8'h41 + i));
      cyc();
    end
    check("drain_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Push while full with a concurrent pop
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'(8'h51 + i));
    tx_ready = 1'b1;
    check("full_head_51", 32'(tx_data), 32'h51);
    wr(A_TXDATA, 32'h55);
    tx_ready = 1'b0;
    rd_chk("txstat_pushpop", A_TXSTAT, 32'h0000_0004);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_byte", 32'(tx_data), 32'(8'h52 + i));
      cyc();
    end
    check("pp_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Timer compare
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    wr(A_CMPHI, 32'h0);
    wr(A_CMPLO, 32'h20);
    ALUResult = A_MTLO;
    #1;
    n = 0;
    while (ReadData != 32'h20 && n < 100) begin
      check("irq_low_wait", 32'(timer_irq), 32'd0);
      cyc();
      n++;
    end
    check("mtime_reach_20", ReadData, 32'h20);
    check("irq_pre", 32'(timer_irq), 32'd0);
    cyc();
    check("irq_rise", 32'(timer_irq), 32'd1);
    rd_chk("mtime_21", A_MTLO, 32'h21);
    wr(A_CMPHI, 32'hFFFF_FFFF);
    check("irq_hold", 32'(timer_irq), 32'd1);
    cyc();
    check("irq_drop", 32'(timer_irq), 32'd0);

    // mtime wrap
    wr(A_MTLO, 32'hFFFF_FFFF);
    wr(A_MTHI, 32'hFFFF_FFFF);
    rd_chk("mt_lo_max", A_MTLO, 32'hFFFF_FFFF);
    rd_chk("mt_hi_max", A_MTHI, 32'hFFFF_FFFF);
    cyc();
    rd_chk("mt_hi_wrap", A_MTHI, 32'h0);
    rd_chk("mt_lo_wrap", A_MTLO, 32'h0);
    check("irq_at_max", 32'(timer_irq), 32'd1);

    // Reset mid-operation
    wr(A_CMPHI, 32'h0);
    wr(A_CMPLO, 32'h0);
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'(8'h61 + i));
    check("pre_rst_irq", 32'(timer_irq), 32'd1);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    rd_chk("pre_rst_txstat", A_TXSTAT, 32'h0000_0003);
    reset = 1'b0;
    MemWrite = 1'b1; ALUResult = 32'h0000_0010; WriteData = 32'hCAFE_F00D;
    cyc();
    MemWrite = 1'b0;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_irq", 32'(timer_irq), 32'd0);
    rd_chk("mid_rst_txstat", A_TXSTAT, 32'h0);
    rd_chk("mid_rst_cmplo", A_CMPLO, 32'hFFFF_FFFF);
    reset = 1'b1;
    rd_chk("post_rst_mt0", A_MTLO, 32'h0);
    cyc();
    rd_chk("post_rst_mt1", A_MTLO, 32'h1);
    rd_chk("ram_kept", 32'h0000_0010, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
